instr_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the byte-addressed, big-endian instruction ROM. It owns the program counter, drives the ROM read address and enable, and latches the returned 32-bit word into an instruction register (IR) for the decoder/control unit. It also computes next-PC for sequential, branch, jump and jump-register flow, squashes wrong-path fetches, and stops on the HALT opcode.

---
 rtl/mips_fetch_pkg.sv | 28 ++
 rtl/next_pc_calc.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mips_fetch_pkg                                         |
// | Description : Shared encodings for the instruction fetch stage:      |
// |               next-PC select codes, default HALT opcode and the      |
// |               fetch state enumeration.                               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mips_fetch_pkg;

  // Next-PC select codes driven by the control unit for the word in IR
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  // Opcode field value that stops the fetch stage
  localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'b111111;

  // Fetch stage states; HALT and FAULT are only left through reset
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : next_pc_calc                                           |
// | Description : Combinational next-PC selection. Targets are relative |
// |               to the PC of the instruction held in IR, not to the    |
// |               current fetch PC. redirect flags any non-sequential    |
// |               selection so the caller can squash the fetched word.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module next_pc_calc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir_pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] w_link;

  // Address following the instruction in IR; base for branch and jump
  assign w_link = ir_pc + 32'd4;

  // Select the next fetch address for the requested flow type
  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    case (pc_src)
      PC_SRC_BRANCH: begin
        next_pc  = w_link + (branch_imm << 2);
        redirect = 1'b1;
      end
      PC_SRC_JUMP: begin
        next_pc  = {w_link[31:28], jump_index, 2'b00};
        redirect = 1'b1;
      end
      PC_SRC_JR: begin
        next_pc  = jr_target;
        redirect = 1'b1;
      end
      default: begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                       |
// | Description : Instruction fetch stage. Owns the PC, drives the ROM   |
// |               read port, latches the returned word into IR, handles  |
// |               branch/jump/jr redirects with one squashed bubble and  |
// |               stops on the HALT opcode.                              |
// |               Optional feature macro: FETCH_BOUNDS_CHECK_EN enables  |
// |               alignment/range checking of every new PC (FAULT).      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_BYTES   = 100,
  parameter logic [5:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        pc_we,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic        rom_rd,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic        fault
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_ir, w_ir_next;
  logic [31:0]  r_ir_pc, w_ir_pc_next;
  logic         r_ir_valid, w_ir_valid_next;

  logic [1:0]   w_src_eff;
  logic [31:0]  w_target;
  logic         w_redirect;
  logic         w_halt_in_ir;
  logic         w_bad_target;

  // Flow control from the decoder only applies to a live instruction
  assign w_src_eff    = r_ir_valid ? pc_src : PC_SRC_SEQ;
  assign w_halt_in_ir = r_ir_valid && (r_ir[31:26] == HALT_OPCODE);

  next_pc_calc u_next_pc_calc (
    .pc         (r_pc),
    .ir_pc      (r_ir_pc),
    .pc_src     (w_src_eff),
    .branch_imm (branch_imm),
    .jump_index (jump_index),
    .jr_target  (jr_target),
    .next_pc    (w_target),
    .redirect   (w_redirect)
  );

`ifdef FETCH_BOUNDS_CHECK_EN
  // Highest byte address at which a full word still fits in the ROM
  localparam logic [31:0] PC_MAX = 32'(ROM_BYTES - 4);

  assign w_bad_target = (w_target[1:0] != 2'b00) || (w_target > PC_MAX);
  assign fault        = (r_state == FAULT);
`else
  assign w_bad_target = 1'b0;
  assign fault        = 1'b0;
`endif

  // Next-state and next-register selection for the fetch FSM
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_pc_next    = r_ir_pc;
    w_ir_valid_next = r_ir_valid;
    case (r_state)
      RUN: begin
        if (pc_we) begin
          if (w_halt_in_ir) begin
            // PC is left pointing past the HALT word; nothing more is fetched
            w_state_next    = HALT;
            w_ir_valid_next = 1'b0;
          end else if (w_bad_target) begin
            w_state_next    = FAULT;
            w_ir_valid_next = 1'b0;
          end else if (!w_redirect) begin
            w_ir_next       = rom_data;
            w_ir_pc_next    = r_pc;
            w_ir_valid_next = 1'b1;
            w_pc_next       = w_target;
          end else begin
            // The word fetched this cycle is on the wrong path: drop it
            w_pc_next       = w_target;
            w_ir_next       = 32'h0000_0000;
            w_ir_valid_next = 1'b0;
          end
        end
      end
      HALT, FAULT: begin
        w_state_next = r_state;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // State and fetch registers; reset overrides stall, halt and fault
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0000_0000;
      r_ir_pc    <= 32'h0000_0000;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_pc    <= w_ir_pc_next;
      r_ir_valid <= w_ir_valid_next;
    end
  end

  assign rom_rd   = (r_state == RUN);
  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                    |
// | Description : Self-checking bench for instr_fetch_unit: directed     |
// |               vector table, bounds/reset sequences and randomized    |
// |               stimulus against a behavioural model.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam int unsigned ROM_BYTES = 100;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [31:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        rom_rd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        fault;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom_bytes [0:255];

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .branch_imm (branch_imm),
    .jump_index (jump_index),
    .jr_target  (jr_target),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .halted     (halted),
    .fault      (fault)
  );

  // Big-endian byte-addressed ROM
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {rom_bytes[b], rom_bytes[b + 8'd1], rom_bytes[b + 8'd2], rom_bytes[b + 8'd3]};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  // Behavioural model state (0 run, 1 halt, 2 fault)
  logic [31:0] m_pc, m_ir, m_irpc;
  logic        m_v;
  int          m_st;

  task automatic model_edge();
    logic [1:0]  src;
    logic [31:0] link, tgt;
    if (Reset) begin
      m_pc = 32'h0; m_ir = 32'h0; m_irpc = 32'h0; m_v = 1'b0; m_st = 0;
    end else if (m_st == 0 && pc_we) begin
      if (m_v && m_ir[31:26] == 6'h3F) begin
        m_st = 1; m_v = 1'b0;
      end else begin
        src  = m_v ? pc_src : 2'd0;
        link = m_irpc + 32'd4;
        case (src)
          2'd0:    tgt = m_pc + 32'd4;
          2'd1:    tgt = link + branch_imm * 32'd4;
          2'd2:    tgt = {link[31:28], jump_index, 2'b00};
          default: tgt = jr_target;
        endcase
        if (BOUNDS_ON && ((tgt % 4) != 0 || tgt > ROM_BYTES - 4)) begin
          m_st = 2; m_v = 1'b0;
        end else if (src == 2'd0) begin
          m_ir = rom_word(m_pc); m_irpc = m_pc; m_v = 1'b1; m_pc = tgt;
        end else begin
          m_pc = tgt; m_ir = 32'h0; m_v = 1'b0;
        end
      end
    end
  endtask

  // One clock edge: model advances with the DUT, outputs sampled 1 unit later
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("rom_addr", rom_addr, m_pc);
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_v});
    chk("halted", {31'b0, halted}, {31'b0, (m_st == 1)});
    chk("fault", {31'b0, fault}, {31'b0, (m_st == 2)});
    chk("rom_rd", {31'b0, rom_rd}, {31'b0, (m_st == 0)});
  endtask

  task automatic set_in(input logic we, input logic [1:0] src, input logic [31:0] imm,
                        input logic [25:0] jidx, input logic [31:0] jr);
    pc_we = we; pc_src = src; branch_imm = imm; jump_index = jidx; jr_target = jr;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_rom_rd", {31'b0, rom_rd}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_irpc;
    logic        e_v;
    logic        e_h;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) rom_bytes[i] = 8'h00;
    for (int i = 0; i < ROM_BYTES / 4; i++) begin
      w = (i == 3) ? 32'hFC00_0000 : 32'h2001_0001 + 32'(i) * 32'h0001_0001;
      rom_bytes[4*i]   = w[31:24];
      rom_bytes[4*i+1] = w[23:16];
      rom_bytes[4*i+2] = w[15:8];
      rom_bytes[4*i+3] = w[7:0];
    end

    tbl[0]  = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h04, 32'h2001_0001, 32'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h08, 32'h2002_0002, 32'h04, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h08, 32'h2002_0002, 32'h04, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 32'h0, 26'h0, 32'h40, 32'h08, 32'h2002_0002, 32'h04, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 32'h08, 32'h2002_0002, 32'h04, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h00, 32'h0, 32'h04, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 32'h0000_0010, 26'h0, 32'h0, 32'h04, 32'h2001_0001, 32'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h08, 32'h2002_0002, 32'h04, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h0C, 32'h2003_0003, 32'h08, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b10, 32'h0, 26'h5, 32'h0, 32'h14, 32'h0, 32'h08, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h18, 32'h2006_0006, 32'h14, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 32'h0, 26'h0, 32'h20, 32'h20, 32'h0, 32'h14, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h24, 32'h2009_0009, 32'h20, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 32'h0, 26'h0, 32'h0C, 32'h0C, 32'h0, 32'h20, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h10, 32'hFC00_0000, 32'h0C, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 32'h10, 32'hFC00_0000, 32'h0C, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 2'b11, 32'h0, 26'h5, 32'h20, 32'h10, 32'hFC00_0000, 32'h0C, 1'b0, 1'b1};

    set_in(1'b1, 2'b00, 32'h0, 26'h0, 32'h0);
    Reset = 1'b1;
    repeat (2) tick();
    do_reset();

    // Directed vector table from reset through stall, redirects and HALT
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].we, tbl[i].src, tbl[i].imm, tbl[i].jidx, tbl[i].jr);
      tick();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_ir", i), ir, tbl[i].e_ir);
      chk($sformatf("tbl%0d_ir_pc", i), ir_pc, tbl[i].e_irpc);
      chk($sformatf("tbl%0d_valid", i), {31'b0, ir_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("tbl%0d_halted", i), {31'b0, halted}, {31'b0, tbl[i].e_h});
      chk($sformatf("tbl%0d_rom_rd", i), {31'b0, rom_rd}, {31'b0, !tbl[i].e_h});
    end

    // Reset leaves HALT
    set_in(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
    do_reset();

    // jr to a misaligned address
    set_in(1'b1, 2'b00, 32'h0, 26'h0, 32'h0);
    tick();
    set_in(1'b1, 2'b11, 32'h0, 26'h0, 32'h62);
    tick();
    chk("jr62_pc", pc, BOUNDS_ON ? 32'h04 : 32'h62);
    chk("jr62_fault", {31'b0, fault}, {31'b0, BOUNDS_ON});
    chk("jr62_rom_rd", {31'b0, rom_rd}, {31'b0, !BOUNDS_ON});
    chk("jr62_valid", {31'b0, ir_valid}, 32'h0);
    set_in(1'b1, 2'b00, 32'h0, 26'h0, 32'h0);
    tick();
    chk("jr62_after_pc", pc, BOUNDS_ON ? 32'h04 : 32'h66);

    // jr just past the last full ROM word
    do_reset();
    tick();
    set_in(1'b1, 2'b11, 32'h0, 26'h0, 32'h64);
    tick();
    chk("jr64_pc", pc, BOUNDS_ON ? 32'h04 : 32'h64);
    chk("jr64_fault", {31'b0, fault}, {31'b0, BOUNDS_ON});

    // Randomized stimulus against the behavioural model
    do_reset();
    for (int n = 0; n < 700; n++) begin
      Reset      = (m_st != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      pc_we      = ($urandom_range(0, 3) != 0);
      pc_src     = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      branch_imm = 32'($urandom_range(0, 15)) - 32'd8;
      jump_index = 26'($urandom_range(0, 31));
      jr_target  = 32'($urandom_range(0, 30)) * 32'd4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      tick();
      check_model();
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
